ahblite_gpio: RTL



---
 rtl/ahblite_gpio_pkg.sv | 43 ++++
 rtl/ahblite_gpio_sync2.sv | 30 +++
 rtl/ahblite_gpio.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ahblite_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO slave: register offsets,
// AHB transfer/size encodings, the registered data-phase record and the
// byte-lane decoder.
package ahblite_gpio_pkg;

   // Register offsets, selected by HADDR[3:2]
   localparam logic [1:0] OFF_OUT = 2'b00;
   localparam logic [1:0] OFF_IN  = 2'b01;
   localparam logic [1:0] OFF_OE  = 2'b10;
   localparam logic [1:0] OFF_IRQ = 2'b11;

   // HTRANS encodings; only HTRANS[1] matters for acceptance
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HSIZE encodings supported by a 32-bit slave
   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Address-phase information carried into the data phase
   typedef struct packed {
      logic       valid;
      logic       write;
      logic [1:0] offset;
      logic [3:0] lanes;
   } dphase_t;

   // Byte lanes touched by a transfer; wider-than-bus sizes touch nothing
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << addr_lo;
         HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahblite_gpio_sync2.sv
// Two-flop synchroniser for asynchronous GPIO inputs, synchronous
// active-high reset to zero.
module gpio_sync2
   import ahblite_gpio_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Resample the pins twice so the second stage is metastability-free
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/ahblite_gpio.sv
// AHB-Lite GPIO slave (zero wait state, always OKAY) on the 0x40000020
// window: OUT DATA, IN DATA (synchronised), OUT ENABLE and IRQ STATUS.
// Optional rising-edge interrupt capture is built when GPIO_IRQ_EN is
// defined; otherwise offset 3 reads zero and gpio_irq is tied low.
module ahblite_gpio
   import ahblite_gpio_pkg::*;
#(
   parameter int                    GPIO_WIDTH = 8,
   parameter logic [GPIO_WIDTH-1:0] OUT_RST    = '0,
   parameter logic [GPIO_WIDTH-1:0] OE_RST     = '0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   output logic                  gpio_irq
);

   dphase_t               r_dp;
   logic [GPIO_WIDTH-1:0] r_out;
   logic [GPIO_WIDTH-1:0] r_oe;
   logic [GPIO_WIDTH-1:0] w_sync;
   logic [GPIO_WIDTH-1:0] w_status_rd;
   logic [GPIO_WIDTH-1:0] w_wdata;
   logic [GPIO_WIDTH-1:0] w_lane_bits;
   logic [31:0]           w_lane_mask32;
   logic [31:0]           w_rdata;
   logic                  w_accept;
   logic                  w_wr;
   logic                  w_unused;

   assign w_accept = HSEL & HREADY & HTRANS[1];

   // Capture the address phase; any non-accepted cycle leaves an idle data phase
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dp <= '0;
      end else begin
         r_dp.valid  <= w_accept;
         r_dp.write  <= HWRITE;
         r_dp.offset <= HADDR[3:2];
         r_dp.lanes  <= lane_mask(HSIZE, HADDR[1:0]);
      end
   end

   // Expand the 4-bit lane mask into a per-bit write mask
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_mask32[gi*8 +: 8] = {8{r_dp.lanes[gi]}};
   end

   assign w_lane_bits = w_lane_mask32[GPIO_WIDTH-1:0];
   assign w_wdata     = HWDATA[GPIO_WIDTH-1:0];
   assign w_wr        = r_dp.valid & r_dp.write;

   // Data-phase writes into the RW registers; reset discards a pending write
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_out <= OUT_RST;
         r_oe  <= OE_RST;
      end else if (w_wr) begin
         case (r_dp.offset)
            OFF_OUT: r_out <= (r_out & ~w_lane_bits) | (w_wdata & w_lane_bits);
            OFF_OE:  r_oe  <= (r_oe  & ~w_lane_bits) | (w_wdata & w_lane_bits);
            default: ;
         endcase
      end
   end

   gpio_sync2 #(
      .WIDTH (GPIO_WIDTH)
   ) u_sync (
      .i_clk  (HCLK),
      .i_srst (HRESET),
      .i_d    (gpio_in),
      .o_q    (w_sync)
   );

`ifdef GPIO_IRQ_EN
   logic [GPIO_WIDTH-1:0] r_prev;
   logic [GPIO_WIDTH-1:0] r_status;
   logic                  r_irq;
   logic [GPIO_WIDTH-1:0] w_rise;
   logic [GPIO_WIDTH-1:0] w_clr;

   assign w_rise = w_sync & ~r_prev;
   assign w_clr  = (w_wr && (r_dp.offset == OFF_IRQ)) ? (w_wdata & w_lane_bits) : '0;

   // Edge capture with write-1-to-clear; a same-cycle edge beats the clear
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_prev   <= '0;
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_prev   <= w_sync;
         r_status <= (r_status & ~w_clr) | w_rise;
         r_irq    <= |(r_status & ~r_oe);
      end
   end

   assign w_status_rd = r_status;
   assign gpio_irq    = r_irq;
`else
   assign w_status_rd = '0;
   assign gpio_irq    = 1'b0;
`endif

   // Read mux, zero outside a valid read data phase
   always_comb begin
      w_rdata = '0;
      if (r_dp.valid && !r_dp.write) begin
         case (r_dp.offset)
            OFF_OUT: w_rdata = 32'(r_out);
            OFF_IN:  w_rdata = 32'(w_sync);
            OFF_OE:  w_rdata = 32'(r_oe);
            default: w_rdata = 32'(w_status_rd);
         endcase
      end
   end

   assign HRDATA    = w_rdata;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign gpio_out  = r_out;
   assign gpio_oe   = r_oe;

   // Address and data bits this slave never decodes
   assign w_unused = ^{HADDR[31:4], HTRANS[0], HWDATA, w_lane_mask32};

endmodule
